ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of buffered key entries; legal values are powers of 2 from 2 to 64.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the maximum clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-high reset, rst, as its first two ports.
REQ-004 Ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock
- ps2_data  in  1  raw PS/2 data
- rd_en  in  1  pop the head entry
- ovf_clr  in  1  clear the sticky overflow flag
- rd_valid  out  1  FIFO not empty
- rd_code  out  8  head scan code
- rd_brk  out  1  head entry is a release (F0-prefixed)
- rd_ext  out  1  head entry is extended (E0-prefixed)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
- overflow  out  1  sticky: an entry was dropped because the FIFO was full
- parity_err  out  1  one-cycle pulse on a parity failure
- frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout

Function
REQ-005 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge SHALL be a registered synchronised 1 followed by a synchronised 0.
REQ-006 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on a falling edge or a timeout.
REQ-007 IDLE: an edge with data=0 (start bit) SHALL go to DATA with bit_cnt=0; an edge with data=1 SHALL keep IDLE.
REQ-008 DATA: each edge SHALL shift data in LSB first; after the 8th bit (bit_cnt 7) the FSM SHALL go to PARITY.
REQ-009 PARITY: the edge SHALL capture the parity bit and go to STOP.
REQ-010 STOP: on the edge with data=1 and odd parity correct over 9 bits, the byte SHALL be delivered to the prefix decoder, then the FSM returns to IDLE.
REQ-011 STOP with data=0: the byte SHALL be discarded, frame_err SHALL pulse for 1 cycle, and the FSM returns to IDLE.
REQ-012 Outside IDLE, if TIMEOUT_CYCLES cycles pass with no edge, the FSM SHALL go to IDLE, discard the partial byte, and pulse frame_err; the timeout counter SHALL restart on every edge.
REQ-013 Prefix decoder: byte 0xE0 SHALL set the pending ext flag and 0xF0 SHALL set the pending brk flag; neither byte is pushed.
REQ-014 Any other byte SHALL be pushed as the entry {ext, brk, code}, after which both pending flags clear.
REQ-015 A pushed entry SHALL be visible on rd_valid/rd_code exactly 1 cycle after the clk edge that samples the stop bit.
REQ-016 The FIFO SHALL be first-word fall-through: rd_code, rd_brk and rd_ext reflect the head whenever rd_valid=1.
REQ-017 rd_en with the FIFO empty SHALL be ignored.
REQ-018 A push with the FIFO full and no simultaneous pop SHALL drop the entry and set overflow.
REQ-019 A push and a pop in the same cycle with the FIFO full SHALL both succeed, leaving fifo_count unchanged.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 overflow SHALL stay set until ovf_clr=1; if ovf_clr and a new overflow occur in the same cycle, overflow SHALL be set.

Reset
REQ-022 rst=1 SHALL asynchronously set FSM=IDLE and clear bit_cnt, the timeout counter, the pending flags, the pointers and the synchronisers (synchronisers to 1).
REQ-023 During reset, rd_valid, fifo_count, overflow, parity_err and frame_err SHALL be 0, and rd_code, rd_brk and rd_ext SHALL be 0.
REQ-024 Reset in the middle of a frame SHALL discard it; the next frame SHALL be received only after a fresh start bit.

Configuration
REQ-025 With macro PS2_RX_PARITY_CHECK_EN defined, a parity mismatch at STOP SHALL discard the byte and pulse parity_err; frame_err SHALL take priority if the stop bit is also bad.
REQ-026 Without PS2_RX_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored, and parity_err SHALL be tied to 0.

Verification
REQ-027 Frame 0x1C (parity 0), then rd_en -> rd_valid=1, rd_code=0x1C, brk=0, ext=0, fifo_count 1->0.
REQ-028 Frames E0, F0, 0x75 -> a single entry code=0x75, brk=1, ext=1; fifo_count=1.
REQ-029 FIFO_DEPTH=4 with 5 frames and no reads -> fifo_count=4, overflow=1; reads return the first 4 codes in order; ovf_clr clears overflow.
REQ-030 Frame 0x1C with flipped parity and the macro defined -> parity_err pulses once, fifo_count stays 0; without the macro -> the entry is pushed.
REQ-031 Stall after 4 data bits for TIMEOUT_CYCLES -> frame_err pulses, FSM=IDLE; a following good frame 0x29 is received correctly.
REQ-032 Assert rst mid-DATA then release, send 0x5A -> only 0x5A is buffered and no error pulses occur.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of the PS/2 receive FIFO: pop handshake, head entry, occupancy and overflow.
// The FIFO side uses modport slave, the consumer uses modport master.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          ovf_clr;
  logic          rd_valid;
  logic [7:0]    rd_code;
  logic          rd_brk;
  logic          rd_ext;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport slave (
    input  rd_en, ovf_clr,
    output rd_valid, rd_code, rd_brk, rd_ext, fifo_count, overflow
  );

  modport master (
    output rd_en, ovf_clr,
    input  rd_valid, rd_code, rd_brk, rd_ext, fifo_count, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix decoder and first-word fall-through key FIFO.
// Optional macro PS2_RX_PARITY_CHECK_EN discards frames with bad odd parity and pulses parity_err.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data=0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit (and parity), delivering the byte
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_rx_fifo_if.slave      rd_if,
  output logic              parity_err,
  output logic              frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          fall, timeout;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit, parity_ok;
  logic [TW-1:0] tmo_cnt;
  logic          ext_pend, brk_pend;
  logic          deliver, ferr_nxt, perr_nxt, perr_q;
  logic          push_req, pop, full, do_push, ovf_set;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall      = clk_prev & ~clk_s2;
  assign timeout   = (state != IDLE) && !fall && (tmo_cnt == '0);
  assign parity_ok = ^{shift, par_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!data_s2) state_nxt = DATA;
        DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (!data_s2)                 ferr_nxt = 1'b1;
          else if (PAR_CHK && !parity_ok) perr_nxt = 1'b1;
          else                          deliver  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Timeout down-counter reloads on every edge; reaching zero outside IDLE aborts the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      frame_err <= ferr_nxt;
      perr_q    <= perr_nxt;
      if (fall)                                tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (state != IDLE && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (fall && !timeout) begin
        if (state == IDLE)   bit_cnt <= 3'd0;
        if (state == DATA) begin
          shift   <= {data_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == PARITY) par_bit <= data_s2;
      end
      if (deliver) begin
        if (shift == 8'hE0)      ext_pend <= 1'b1;
        else if (shift == 8'hF0) brk_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  assign parity_err = PAR_CHK ? perr_q : 1'b0;

  assign push_req = deliver && (shift != 8'hE0) && (shift != 8'hF0);
  assign pop      = rd_if.rd_en && (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_push  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ext_pend, brk_pend, shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      rd_if.overflow    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      // A new overflow wins over a simultaneous clear.
      rd_if.overflow <= ovf_set | (rd_if.overflow & ~rd_if.ovf_clr);
    end
  end

  assign rd_if.rd_valid   = (count != '0);
  assign rd_if.fifo_count = count;
  assign rd_if.rd_code    = rd_if.rd_valid ? mem[rd_ptr][7:0] : 8'd0;
  assign rd_if.rd_brk     = rd_if.rd_valid ? mem[rd_ptr][8]   : 1'b0;
  assign rd_if.rd_ext     = rd_if.rd_valid ? mem[rd_ptr][9]   : 1'b0;
endmodule
